// File: rtl/spi_dac_pkg.sv
// -----------------------------------------------------------------------------
// spi_dac_pkg
// Shared definitions for the two-channel SPI DAC sequencer: FSM state
// encoding, frame size, DAC command header bits and the frame builder.
// Optional build macro used by the sequencer: SPI_DAC_CHANGE_DETECT_EN.
// -----------------------------------------------------------------------------
package spi_dac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_LATCH,
    ST_ACK
  } state_e;

  localparam int   FRAME_BITS = 16;
  localparam logic GAIN_1X    = 1'b1;
  localparam logic ACTIVE     = 1'b1;

  // Frame layout: {channel, 0, gain, active, data[7:0], 4'b0000}
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic       chan,
                                                        input logic [7:0] data);
    return {chan, 1'b0, GAIN_1X, ACTIVE, data, 4'h0};
  endfunction

endpackage

// File: rtl/spi_dac_rr_arbiter.sv
// -----------------------------------------------------------------------------
// spi_dac_rr_arbiter
// Two-port round-robin arbiter. Grant is combinational from the requests and
// the priority pointer; the pointer moves to the granted port on `advance`.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   req[1:0]     : requests (bit 0 = port 0, bit 1 = port 1)
//   advance      : a grant is being taken this cycle
//   grant[1:0]   : one-hot grant (zero when no request)
// -----------------------------------------------------------------------------
module spi_dac_rr_arbiter
  import spi_dac_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // last_q = 1 means port 1 was granted last, so port 0 wins the next tie.
  // Resetting it to 1 gives port 0 the first tie.
  logic last_q;
  logic last_d;

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (advance && (grant != 2'b00)) begin
      last_d = grant[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/spi_dac_sequencer.sv
// -----------------------------------------------------------------------------
// spi_dac_sequencer
// Arbitrates two DAC write requesters round-robin, shifts one 16-bit frame
// per grant out over SPI (mode 0, MSB first), pulses LDAC and acknowledges.
// Parameter:
//   HALF_SCLK    : clk cycles per SCLK half period (>= 1)
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   req0/data0   : port 0 (trigger reference, DAC channel A), ack0 pulse out
//   req1/data1   : port 1 (vertical offset, DAC channel B), ack1 pulse out
//   cs_n, sclk, mosi, ldac_n : DAC interface
//   busy         : high from the grant cycle through the ack cycle
// Build option:
//   SPI_DAC_CHANGE_DETECT_EN : keep the last written value per channel and
//   acknowledge a repeated value immediately without SPI traffic.
// -----------------------------------------------------------------------------
module spi_dac_sequencer
  import spi_dac_pkg::*;
#(
  parameter int HALF_SCLK = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       cs_n,
  output logic       sclk,
  output logic       mosi,
  output logic       ldac_n,
  output logic       busy
);

  localparam int DIV_W = (HALF_SCLK > 1) ? $clog2(HALF_SCLK) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_SCLK - 1);

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [3:0]            bit_q, bit_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  ldac_n_q, ldac_n_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  chan_q, chan_d;

  logic [1:0] grant;
  logic       advance;
  logic       grant_chan;
  logic [7:0] grant_data;
  logic       div_wrap;
  logic       skip;

  assign advance    = (state_q == ST_IDLE) && (req0 || req1);
  assign grant_chan = grant[1];
  assign grant_data = grant[1] ? data1 : data0;
  assign div_wrap   = (div_q == DIV_LAST);

  spi_dac_rr_arbiter u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1, req0}),
    .advance (advance),
    .grant   (grant)
  );

`ifdef SPI_DAC_CHANGE_DETECT_EN
  logic [7:0] shadow_a_q, shadow_a_d;
  logic [7:0] shadow_b_q, shadow_b_d;

  assign skip = (grant_chan ? shadow_b_q : shadow_a_q) == grant_data;

  // Shadows take the value of a frame that actually reached the DAC.
  always_comb begin
    shadow_a_d = shadow_a_q;
    shadow_b_d = shadow_b_q;
    if ((state_q == ST_LATCH) && div_wrap) begin
      if (chan_q) shadow_b_d = frame_q[11:4];
      else        shadow_a_d = frame_q[11:4];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_a_q <= 8'h00;
      shadow_b_q <= 8'h00;
    end else begin
      shadow_a_q <= shadow_a_d;
      shadow_b_q <= shadow_b_d;
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    ldac_n_d = ldac_n_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    frame_d  = frame_q;
    chan_d   = chan_q;

    unique case (state_q)
      ST_IDLE: begin
        if (advance) begin
          frame_d = build_frame(grant_chan, grant_data);
          chan_d  = grant_chan;
          div_d   = '0;
          bit_d   = 4'd15;
          if (skip) begin
            state_d = ST_ACK;
            ack0_d  = ~grant_chan;
            ack1_d  = grant_chan;
          end else begin
            state_d = ST_SHIFT;
            cs_n_d  = 1'b0;
            mosi_d  = frame_d[FRAME_BITS-1];
          end
        end
      end

      // Each bit: sclk low for HALF_SCLK cycles, then high. The next bit is
      // presented on the falling edge; after bit 0 the frame is closed.
      ST_SHIFT: begin
        div_d = div_wrap ? '0 : div_q + DIV_W'(1);
        if (div_wrap) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 4'd0) begin
              state_d = ST_CS_HOLD;
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
            end else begin
              bit_d  = bit_q - 4'd1;
              mosi_d = frame_q[bit_q - 4'd1];
            end
          end
        end
      end

      ST_CS_HOLD: begin
        div_d = div_wrap ? '0 : div_q + DIV_W'(1);
        if (div_wrap) begin
          state_d  = ST_LATCH;
          ldac_n_d = 1'b0;
        end
      end

      ST_LATCH: begin
        div_d = div_wrap ? '0 : div_q + DIV_W'(1);
        if (div_wrap) begin
          state_d  = ST_ACK;
          ldac_n_d = 1'b1;
          ack0_d   = ~chan_q;
          ack1_d   = chan_q;
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= 4'd15;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      ldac_n_q <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      ldac_n_q <= ldac_n_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
    end
  end

  // Frame data and channel are only meaningful after a grant loads them.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
    chan_q  <= chan_d;
  end

  assign cs_n   = cs_n_q;
  assign sclk   = sclk_q;
  assign mosi   = mosi_q;
  assign ldac_n = ldac_n_q;
  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign busy   = ~reset & ((state_q != ST_IDLE) | req0 | req1);

endmodule
